// File: rtl/tape_mem_arbiter.sv
// Arbitrates tape-loader writes and cassette reads onto a single byte-wide memory port.
// Define TAPE_ARB_LEN_EN to add tape-length tracking and end-of-tape read completion.
module tape_mem_arbiter #(
    parameter int unsigned AW     = 25,
    parameter int unsigned TO_CYC = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_ovf,
    input  logic          cas_req,
    input  logic [AW-1:0] cas_addr,
    output logic          cas_busy,
    output logic [7:0]    cas_data,
    output logic          cas_valid,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ready,
    output logic          mem_err
`ifdef TAPE_ARB_LEN_EN
    ,
    output logic [AW-1:0] tape_len,
    output logic          cas_eof
`endif
);

    localparam int unsigned CW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t        state_q;
    logic          buf_full_q;
    logic [AW-1:0] buf_addr_q;
    logic [7:0]    buf_data_q;
    logic          pend_q;
    logic [AW-1:0] pend_addr_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] mem_addr_q;
    logic [7:0]    mem_din_q;
    logic          mem_we_q;
    logic          mem_rd_q;
    logic [7:0]    cas_data_q;
    logic          cas_valid_q;
    logic          dl_ovf_q;
    logic          mem_err_q;

    logic          to_hit;
    logic          drain;
    logic          wr_accept;
    logic          wr_drop;
    logic          rd_accept;
    logic          eff_full;
    logic          eff_pend;
    logic [AW-1:0] eff_waddr;
    logic [7:0]    eff_wdata;
    logic [AW-1:0] eff_raddr;

`ifdef TAPE_ARB_LEN_EN
    logic [AW-1:0] tape_len_q;
    logic [AW-1:0] tape_len_d;
    logic [AW:0]   len_next;
    logic          dl_active_q;
    logic          eof_q;
    logic          cas_eof_q;
`endif

    // IDLE looks through the buffer/pending register so a fresh strobe starts an access next cycle.
    always_comb begin
        to_hit    = (cnt_q == TO_LAST);
        drain     = (state_q == WRITE) && (mem_ready || to_hit);
        wr_accept = dl_wr && (!buf_full_q || drain);
        wr_drop   = dl_wr && buf_full_q && !drain;
        rd_accept = cas_req && !pend_q;
        eff_full  = buf_full_q || wr_accept;
        eff_waddr = buf_full_q ? buf_addr_q : dl_addr;
        eff_wdata = buf_full_q ? buf_data_q : dl_data;
        eff_pend  = pend_q || rd_accept;
        eff_raddr = pend_q ? pend_addr_q : cas_addr;
    end

`ifdef TAPE_ARB_LEN_EN
    always_comb begin
        len_next   = {1'b0, dl_addr} + {{AW{1'b0}}, 1'b1};
        tape_len_d = (dl_active && !dl_active_q) ? '0 : tape_len_q;
        if (wr_accept && (len_next > {1'b0, tape_len_d}))
            tape_len_d = len_next[AW] ? '1 : len_next[AW-1:0];
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            buf_full_q  <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            cas_data_q  <= '0;
            cas_valid_q <= 1'b0;
            dl_ovf_q    <= 1'b0;
            mem_err_q   <= 1'b0;
`ifdef TAPE_ARB_LEN_EN
            tape_len_q  <= '0;
            dl_active_q <= 1'b0;
            eof_q       <= 1'b0;
            cas_eof_q   <= 1'b0;
`endif
        end else begin
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            cas_valid_q <= 1'b0;
`ifdef TAPE_ARB_LEN_EN
            cas_eof_q   <= 1'b0;
            dl_active_q <= dl_active;
            tape_len_q  <= tape_len_d;
`endif
            if (wr_accept) begin
                buf_full_q <= 1'b1;
                buf_addr_q <= dl_addr;
                buf_data_q <= dl_data;
            end else if (drain) begin
                buf_full_q <= 1'b0;
            end
            if (wr_drop)
                dl_ovf_q <= 1'b1;
            if (rd_accept) begin
                pend_q      <= 1'b1;
                pend_addr_q <= cas_addr;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (eff_full) begin
                        state_q    <= WRITE;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= eff_waddr;
                        mem_din_q  <= eff_wdata;
                    end else if (eff_pend && !dl_active) begin
                        state_q <= READ;
`ifdef TAPE_ARB_LEN_EN
                        if (eff_raddr >= tape_len_q) begin
                            eof_q <= 1'b1;
                        end else begin
                            eof_q      <= 1'b0;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= eff_raddr;
                        end
`else
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= eff_raddr;
`endif
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state_q <= IDLE;
                    end else if (to_hit) begin
                        state_q   <= IDLE;
                        mem_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                READ: begin
`ifdef TAPE_ARB_LEN_EN
                    if (eof_q) begin
                        state_q     <= IDLE;
                        pend_q      <= 1'b0;
                        cas_data_q  <= '0;
                        cas_valid_q <= 1'b1;
                        cas_eof_q   <= 1'b1;
                    end else
`endif
                    if (mem_ready) begin
                        state_q     <= IDLE;
                        pend_q      <= 1'b0;
                        cas_data_q  <= mem_dout;
                        cas_valid_q <= 1'b1;
                    end else if (to_hit) begin
                        state_q     <= IDLE;
                        pend_q      <= 1'b0;
                        cas_data_q  <= '0;
                        cas_valid_q <= 1'b1;
                        mem_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dl_ovf    = dl_ovf_q;
    assign cas_busy  = pend_q;
    assign cas_data  = cas_data_q;
    assign cas_valid = cas_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign mem_rd    = mem_rd_q;
    assign mem_err   = mem_err_q;
`ifdef TAPE_ARB_LEN_EN
    assign tape_len  = tape_len_q;
    assign cas_eof   = cas_eof_q;
`endif

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Scoreboard bench for tape_mem_arbiter; the EOF scenario is built when TAPE_ARB_LEN_EN is defined.
module tb_tape_mem_arbiter;

    localparam int AW = 25;
    localparam int TO = 8;
    localparam byte EV_W = 8'h57;
    localparam byte EV_R = 8'h52;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dl_active = 1'b0;
    logic          dl_wr = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [7:0]    dl_data = '0;
    logic          dl_ovf;
    logic          cas_req = 1'b0;
    logic [AW-1:0] cas_addr = '0;
    logic          cas_busy;
    logic [7:0]    cas_data;
    logic          cas_valid;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          mem_rd;
    logic [7:0]    mem_dout = 8'hEE;
    logic          mem_ready = 1'b0;
    logic          mem_err;
`ifdef TAPE_ARB_LEN_EN
    logic [AW-1:0] tape_len;
    logic          cas_eof;
`endif

    always #5 clk = ~clk;

    tape_mem_arbiter #(.AW(AW), .TO_CYC(TO)) dut (
        .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_ovf(dl_ovf),
        .cas_req(cas_req), .cas_addr(cas_addr), .cas_busy(cas_busy),
        .cas_data(cas_data), .cas_valid(cas_valid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready), .mem_err(mem_err)
`ifdef TAPE_ARB_LEN_EN
        , .tape_len(tape_len), .cas_eof(cas_eof)
`endif
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [7:0] data; bit eof; bit chk_lat; } rd_t;

    wr_t           wr_q[$];
    rd_t           rd_q[$];
    logic [AW-1:0] rda_q[$];
    byte           ev_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, req_cyc = 0;
    int we_cnt = 0, rd_cnt = 0, val_cnt = 0;
    int rd_cyc = 0, val_cyc = 0, rdy_cyc = 0;
    bit both_seen = 0;

    int         resp_delay = 3;
    bit         resp_en = 1;
    logic [7:0] resp_data = 8'h00;
    int         rcnt = 0;

    always @(posedge clk) cyc++;

    // Memory model: mem_ready pulses resp_delay cycles after the access strobe.
    always begin
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_dout  = 8'hEE;
        if (!reset) begin
            rcnt = 0;
        end else begin
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    mem_ready = 1'b1;
                    mem_dout  = resp_data;
                end
            end
            if ((mem_we || mem_rd) && resp_en) rcnt = resp_delay;
        end
    end

    wr_t mw;
    rd_t mr;
    logic [AW-1:0] ma;
    always @(negedge clk) begin
        if (reset) begin
            if (mem_ready) rdy_cyc = cyc;
            if (mem_we && mem_rd) both_seen = 1;
            if (mem_we) begin
                we_cnt++;
                ev_q.push_back(EV_W);
                n_chk++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_mem_we: addr=%h din=%h, required no write", mem_addr, mem_din);
                end else begin
                    mw = wr_q.pop_front();
                    if ({mem_addr, mem_din} !== {mw.addr, mw.data}) begin
                        n_fail++;
                        $display("FAIL write_beat: addr/din=%h/%h, required %h/%h", mem_addr, mem_din, mw.addr, mw.data);
                    end
                end
            end
            if (mem_rd) begin
                rd_cnt++;
                rd_cyc = cyc;
                ev_q.push_back(EV_R);
                n_chk++;
                if (rda_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_mem_rd: addr=%h, required no read", mem_addr);
                end else begin
                    ma = rda_q.pop_front();
                    if (mem_addr !== ma) begin
                        n_fail++;
                        $display("FAIL read_addr: mem_addr=%h, required %h", mem_addr, ma);
                    end
                end
            end
            if (cas_valid) begin
                val_cnt++;
                val_cyc = cyc;
                n_chk++;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_cas_valid: cas_data=%h, required no completion", cas_data);
                end else begin
                    mr = rd_q.pop_front();
                    if (cas_data !== mr.data) begin
                        n_fail++;
                        $display("FAIL cas_data: got %h, required %h", cas_data, mr.data);
                    end
                    n_chk++;
                    if (cas_busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL busy_with_valid: cas_busy=%b, required 0", cas_busy);
                    end
                    if (mr.chk_lat) begin
                        n_chk++;
                        if (cyc != rdy_cyc + 1) begin
                            n_fail++;
                            $display("FAIL ready_to_valid: valid cycle %0d, required %0d", cyc, rdy_cyc + 1);
                        end
                    end
`ifdef TAPE_ARB_LEN_EN
                    n_chk++;
                    if (cas_eof !== mr.eof) begin
                        n_fail++;
                        $display("FAIL cas_eof: got %b, required %b", cas_eof, mr.eof);
                    end
`endif
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_quiet(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (wr_q.size() == 0 && rd_q.size() == 0 && rcnt == 0 && !cas_busy && !mem_ready) begin
                ok = 1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_quiet: outstanding wr=%0d rd=%0d after %0d cycles, required 0", wr_q.size(), rd_q.size(), budget);
        end
        tick(2);
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [7:0] d, input bit push);
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
        if (push) wr_q.push_back('{a, d});
        tick(1);
        dl_wr = 1'b0;
    endtask

    task automatic drive_read(input logic [AW-1:0] a, input logic [7:0] d, input bit eof,
                              input bit lat, input bit mem, input bit valid);
        cas_req = 1'b1; cas_addr = a;
        req_cyc = cyc;
        if (valid) rd_q.push_back('{d, eof, lat});
        if (mem) rda_q.push_back(a);
        tick(1);
        cas_req = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        logic [AW+21:0] obs;
        reset = 1'b0;
        dl_wr = 1'b1; dl_addr = 25'h5; cas_req = 1'b1;
        tick(3);
        obs = {mem_addr, mem_din, mem_we, mem_rd, cas_data, cas_valid, cas_busy, dl_ovf, mem_err};
        n_chk++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: %h, required 0", obs);
        end
`ifdef TAPE_ARB_LEN_EN
        n_chk++;
        if ({tape_len, cas_eof} !== '0) begin
            n_fail++;
            $display("FAIL reset_len: tape_len=%h cas_eof=%b, required 0", tape_len, cas_eof);
        end
`endif
        dl_wr = 1'b0; cas_req = 1'b0;
        reset = 1'b1;
        tick(2);
        n_chk++;
        if ({cas_busy, mem_we, mem_rd} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy/we/rd=%b, required 000", {cas_busy, mem_we, mem_rd});
        end
    endtask

    task automatic test_single_write();
        int w0 = we_cnt;
        resp_delay = 3;
        drive_write(25'h10, 8'hA5, 1);
        wait_quiet(30);
        n_chk++;
        if (we_cnt - w0 != 1) begin
            n_fail++;
            $display("FAIL single_write_count: mem_we pulses=%0d, required 1", we_cnt - w0);
        end
        n_chk++;
        if (dl_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL single_write_ovf: dl_ovf=%b, required 0", dl_ovf);
        end
    endtask

    task automatic test_drain_accept();
        int w0 = we_cnt;
        bit seen = 0;
        resp_delay = 2;
        drive_write(25'h40, 8'h11, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                seen = 1;
                break;
            end
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL drain_ready: mem_ready not seen, required within 20 cycles");
        end
        dl_wr = 1'b1; dl_addr = 25'h41; dl_data = 8'h22;
        wr_q.push_back('{25'h41, 8'h22});
        tick(1);
        dl_wr = 1'b0;
        wait_quiet(30);
        n_chk++;
        if (we_cnt - w0 != 2 || dl_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_accept: writes=%0d dl_ovf=%b, required 2 and 0", we_cnt - w0, dl_ovf);
        end
    endtask

    task automatic test_overflow();
        int w0 = we_cnt;
        resp_delay = 5;
        dl_wr = 1'b1; dl_addr = 25'h11; dl_data = 8'h33;
        wr_q.push_back('{25'h11, 8'h33});
        tick(1);
        dl_addr = 25'h12; dl_data = 8'h44;
        tick(1);
        dl_wr = 1'b0;
        wait_quiet(30);
        n_chk++;
        if (dl_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flag: dl_ovf=%b, required 1", dl_ovf);
        end
        n_chk++;
        if (we_cnt - w0 != 1) begin
            n_fail++;
            $display("FAIL overflow_writes: mem_we pulses=%0d, required 1", we_cnt - w0);
        end
        apply_reset();
        n_chk++;
        if (dl_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: dl_ovf=%b, required 0", dl_ovf);
        end
    endtask

    task automatic test_read_hold();
        int r0 = rd_cnt;
        resp_delay = 3; resp_data = 8'h3C;
        dl_active = 1'b1;
        drive_read(25'h20, 8'h3C, 0, 1, 1, 1);
        tick(6);
        n_chk++;
        if (rd_cnt != r0 || cas_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_hold: mem_rd=%0d busy=%b, required 0 and 1", rd_cnt - r0, cas_busy);
        end
        dl_active = 1'b0;
        wait_quiet(30);
        n_chk++;
        if (rd_cnt - r0 != 1) begin
            n_fail++;
            $display("FAIL read_release: mem_rd=%0d, required 1", rd_cnt - r0);
        end
    endtask

    task automatic test_read_latency();
        int r0 = rd_cnt;
        int rc;
        resp_delay = 1; resp_data = 8'h5A;
        cas_req = 1'b1; cas_addr = 25'h55;
        rc = cyc;
        rd_q.push_back('{8'h5A, 0, 1});
        rda_q.push_back(25'h55);
        tick(1);
        cas_addr = 25'h66;
        tick(1);
        cas_req = 1'b0;
        wait_quiet(30);
        n_chk++;
        if (rd_cyc != rc + 1) begin
            n_fail++;
            $display("FAIL req_to_rd: mem_rd cycle %0d, required %0d", rd_cyc, rc + 1);
        end
        n_chk++;
        if (rd_cnt - r0 != 1) begin
            n_fail++;
            $display("FAIL busy_ignore: mem_rd=%0d, required 1", rd_cnt - r0);
        end
    endtask

    task automatic test_priority();
        resp_delay = 2; resp_data = 8'h77;
        ev_q.delete();
        both_seen = 0;
        dl_wr = 1'b1; dl_addr = 25'h70; dl_data = 8'h99;
        wr_q.push_back('{25'h70, 8'h99});
        cas_req = 1'b1; cas_addr = 25'h71;
        rd_q.push_back('{8'h77, 0, 1});
        rda_q.push_back(25'h71);
        tick(1);
        dl_wr = 1'b0; cas_req = 1'b0;
        wait_quiet(40);
        n_chk++;
        if (ev_q.size() != 2) begin
            n_fail++;
            $display("FAIL priority_count: %0d accesses, required 2", ev_q.size());
        end else if ({ev_q[0], ev_q[1]} !== {EV_W, EV_R}) begin
            n_fail++;
            $display("FAIL priority_order: %c then %c, required W then R", ev_q[0], ev_q[1]);
        end
        n_chk++;
        if (both_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL we_rd_overlap: overlap=%b, required 0", both_seen);
        end
    endtask

    task automatic test_timeout();
        int r0;
        n_chk++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_err_before: %b, required 0", mem_err);
        end
        resp_en = 0;
        drive_read(25'h30, 8'h00, 0, 0, 1, 1);
        wait_quiet(40);
        n_chk++;
        if (val_cyc - rd_cyc != TO) begin
            n_fail++;
            $display("FAIL timeout_len: %0d cycles, required %0d", val_cyc - rd_cyc, TO);
        end
        n_chk++;
        if (mem_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err: mem_err=%b, required 1", mem_err);
        end
        resp_en = 1; resp_delay = 2; resp_data = 8'hC3;
        r0 = rd_cnt;
        drive_read(25'h31, 8'hC3, 0, 1, 1, 1);
        wait_quiet(30);
        n_chk++;
        if (rd_cnt - r0 != 1) begin
            n_fail++;
            $display("FAIL timeout_recover: mem_rd=%0d, required 1", rd_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        logic [AW+21:0] obs;
        int v0;
        resp_en = 0;
        v0 = val_cnt;
        drive_read(25'h44, 8'h00, 0, 0, 1, 0);
        tick(2);
        reset = 1'b0;
        #2;
        obs = {mem_addr, mem_din, mem_we, mem_rd, cas_data, cas_valid, cas_busy, dl_ovf, mem_err};
        n_chk++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL async_reset: %h, required 0", obs);
        end
        tick(3);
        reset = 1'b1;
        resp_en = 1;
        tick(6);
        n_chk++;
        if (val_cnt != v0 || cas_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abandon: cas_valid=%0d busy=%b, required 0 and 0", val_cnt - v0, cas_busy);
        end
    endtask

`ifdef TAPE_ARB_LEN_EN
    task automatic test_eof();
        int r0;
        logic [7:0] d;
        resp_delay = 1;
        dl_active = 1'b1;
        for (int a = 0; a < 100; a++) begin
            d = 8'(a) ^ 8'h5A;
            drive_write(AW'(a), d, 1);
            wait_quiet(20);
        end
        dl_active = 1'b0;
        tick(1);
        n_chk++;
        if (tape_len !== AW'(100)) begin
            n_fail++;
            $display("FAIL tape_len: %0d, required 100", tape_len);
        end
        r0 = rd_cnt;
        drive_read(AW'(100), 8'h00, 1, 0, 0, 1);
        wait_quiet(20);
        n_chk++;
        if (rd_cnt != r0) begin
            n_fail++;
            $display("FAIL eof_no_read: mem_rd=%0d, required 0", rd_cnt - r0);
        end
        n_chk++;
        if (val_cyc != req_cyc + 2) begin
            n_fail++;
            $display("FAIL eof_latency: valid cycle %0d, required %0d", val_cyc, req_cyc + 2);
        end
        resp_data = 8'h68;
        drive_read(AW'(50), 8'h68, 0, 1, 1, 1);
        wait_quiet(20);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_drain_accept();
        test_overflow();
        test_read_hold();
        test_read_latency();
        test_priority();
        test_timeout();
        test_reset_mid();
`ifdef TAPE_ARB_LEN_EN
        apply_reset();
        test_eof();
`endif
        n_chk++;
        if (wr_q.size() != 0 || rd_q.size() != 0 || rda_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: wr=%0d rd=%0d rda=%0d, required 0", wr_q.size(), rd_q.size(), rda_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
